// File: rtl/ultrasonic_ranger_mc_pkg.sv
// Shared types and default 50 MHz timing for the multi-channel ultrasonic ranger.
// Also provides the channel-index width helper used by the top's port list.
package ultrasonic_ranger_mc_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_TRIG,
        S_WAIT_RISE,
        S_MEASURE,
        S_GAP
    } state_e;

    localparam int DEF_CHANNELS       = 4;
    localparam int DEF_RANGE_WIDTH    = 24;
    localparam int DEF_TRIG_CYCLES    = 500;
    localparam int DEF_TIMEOUT_CYCLES = 1900000;
    localparam int DEF_GAP_CYCLES     = 250000;

    // A single sensor still needs a 1-bit channel field.
    function automatic int chan_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/ultrasonic_ranger_mc_echo_sync_edge.sv
// Two-flop synchronizer for one asynchronous echo line, plus rise/fall pulses
// taken from the synchronized level.
module echo_sync_edge (
    input  logic clk_i,
    input  logic rst_i,
    input  logic echo_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    logic meta_q;
    logic sync_q;
    logic prev_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            prev_q <= 1'b0;
        end else begin
            meta_q <= echo_i;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign level_o = sync_q;
    assign rise_o  = sync_q & ~prev_q;
    assign fall_o  = ~sync_q & prev_q;

endmodule

// File: rtl/ultrasonic_ranger_mc.sv
// Round-robin controller: triggers one sensor at a time, times its echo pulse
// in clock cycles and publishes a per-channel range with a one-cycle strobe.
module ultrasonic_ranger_mc
    import ultrasonic_ranger_mc_pkg::*;
#(
    parameter int CHANNELS       = DEF_CHANNELS,
    parameter int RANGE_WIDTH    = DEF_RANGE_WIDTH,
    parameter int TRIG_CYCLES    = DEF_TRIG_CYCLES,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
    parameter int GAP_CYCLES     = DEF_GAP_CYCLES
) (
    input  logic                               clk_i,
    input  logic                               rst_i,
    input  logic                               enable_i,
    input  logic [CHANNELS-1:0]                echo_i,
    output logic [CHANNELS-1:0]                trigger_o,
    output logic [CHANNELS*RANGE_WIDTH-1:0]    range_o,
    output logic                               result_valid_o,
    output logic [chan_width(CHANNELS)-1:0]    result_chan_o,
    output logic                               result_timeout_o,
    output logic                               busy_o
);

    localparam int CW = chan_width(CHANNELS);
    localparam int TW = $clog2(TRIG_CYCLES + 1);
    localparam int OW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int GW = $clog2(GAP_CYCLES + 1);

    logic [CHANNELS-1:0] level_w;
    logic [CHANNELS-1:0] rise_w;
    logic [CHANNELS-1:0] fall_w;

    for (genvar g = 0; g < CHANNELS; g++) begin : g_sync
        echo_sync_edge u_sync (
            .clk_i   (clk_i),
            .rst_i   (rst_i),
            .echo_i  (echo_i[g]),
            .level_o (level_w[g]),
            .rise_o  (rise_w[g]),
            .fall_o  (fall_w[g])
        );
    end

    state_e                          state_q;
    logic [CW-1:0]                   ch_q;
    logic [TW-1:0]                   trig_cnt_q;
    logic [OW-1:0]                   tmo_q;
    logic [GW-1:0]                   gap_cnt_q;
    logic [RANGE_WIDTH-1:0]          width_q;
    logic [CHANNELS-1:0]             trigger_q;
    logic [CHANNELS*RANGE_WIDTH-1:0] range_q;
    logic                            result_valid_q;
    logic [CW-1:0]                   result_chan_q;
    logic                            result_timeout_q;

    logic                   sel_level;
    logic                   sel_rise;
    logic                   sel_fall;
    logic [CW-1:0]          ch_d;
    logic [OW-1:0]          tmo_d;
    logic                   tmo_hit;
    logic [RANGE_WIDTH-1:0] width_d;

    assign sel_level = level_w[ch_q];
    assign sel_rise  = rise_w[ch_q];
    assign sel_fall  = fall_w[ch_q];
    assign ch_d      = (ch_q == CW'(CHANNELS - 1)) ? '0 : ch_q + 1'b1;
    assign tmo_d     = tmo_q + 1'b1;
    assign tmo_hit   = (tmo_d == OW'(TIMEOUT_CYCLES));
    assign width_d   = (width_q == '1) ? width_q : width_q + 1'b1;

    // The rise cycle already counts as one high cycle, so the width starts at 1
    // and the latched result matches the raw pulse length exactly.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q          <= S_IDLE;
            ch_q             <= '0;
            trig_cnt_q       <= '0;
            tmo_q            <= '0;
            gap_cnt_q        <= '0;
            width_q          <= '0;
            trigger_q        <= '0;
            range_q          <= '0;
            result_valid_q   <= 1'b0;
            result_chan_q    <= '0;
            result_timeout_q <= 1'b0;
        end else begin
            result_valid_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (enable_i) begin
                        state_q    <= S_TRIG;
                        trig_cnt_q <= '0;
                        trigger_q  <= CHANNELS'(1) << ch_q;
                    end
                end
                S_TRIG: begin
                    if (trig_cnt_q == TW'(TRIG_CYCLES - 1)) begin
                        state_q   <= S_WAIT_RISE;
                        trigger_q <= '0;
                        tmo_q     <= '0;
                    end else begin
                        trig_cnt_q <= trig_cnt_q + 1'b1;
                    end
                end
                S_WAIT_RISE: begin
                    tmo_q <= tmo_d;
                    if (tmo_hit) begin
                        range_q[ch_q*RANGE_WIDTH +: RANGE_WIDTH] <= '1;
                        result_valid_q   <= 1'b1;
                        result_timeout_q <= 1'b1;
                        result_chan_q    <= ch_q;
                        gap_cnt_q        <= '0;
                        state_q          <= S_GAP;
                    end else if (sel_rise) begin
                        width_q <= RANGE_WIDTH'(1);
                        state_q <= S_MEASURE;
                    end
                end
                S_MEASURE: begin
                    tmo_q <= tmo_d;
                    if (tmo_hit) begin
                        range_q[ch_q*RANGE_WIDTH +: RANGE_WIDTH] <= '1;
                        result_valid_q   <= 1'b1;
                        result_timeout_q <= 1'b1;
                        result_chan_q    <= ch_q;
                        gap_cnt_q        <= '0;
                        state_q          <= S_GAP;
                    end else if (sel_fall) begin
                        range_q[ch_q*RANGE_WIDTH +: RANGE_WIDTH] <= width_q;
                        result_valid_q   <= 1'b1;
                        result_timeout_q <= 1'b0;
                        result_chan_q    <= ch_q;
                        gap_cnt_q        <= '0;
                        state_q          <= S_GAP;
                    end else if (sel_level) begin
                        width_q <= width_d;
                    end
                end
                S_GAP: begin
                    if (gap_cnt_q == GW'(GAP_CYCLES - 1)) begin
                        ch_q <= ch_d;
                        if (enable_i) begin
                            state_q    <= S_TRIG;
                            trig_cnt_q <= '0;
                            trigger_q  <= CHANNELS'(1) << ch_d;
                        end else begin
                            state_q <= S_IDLE;
                        end
                    end else begin
                        gap_cnt_q <= gap_cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_q   <= S_IDLE;
                    trigger_q <= '0;
                end
            endcase
        end
    end

    assign trigger_o        = trigger_q;
    assign range_o          = range_q;
    assign result_valid_o   = result_valid_q;
    assign result_chan_o    = result_chan_q;
    assign result_timeout_o = result_timeout_q;
    assign busy_o           = (state_q != S_IDLE);

endmodule

// File: tb/tb_ultrasonic_ranger_mc.sv
// Scoreboard bench for the multi-channel ranger: expected results are queued
// as echoes are driven and matched against each result strobe.
module tb_ultrasonic_ranger_mc;

    localparam int CH   = 2;
    localparam int RW   = 8;
    localparam int TRIG = 4;
    localparam int TMO  = 100;
    localparam int GAP  = 10;

    typedef struct {
        int     chan;
        int     val;
        bit     tmo;
        longint expCyc;
    } exp_t;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            enable = 1'b0;
    logic [CH-1:0]   echo = '0;
    logic [CH-1:0]   trigger;
    logic [CH*RW-1:0] rangeBus;
    logic            resultValid;
    logic [0:0]      resultChan;
    logic            resultTimeout;
    logic            busy;

    int     assertCount = 0;
    int     failCount = 0;
    longint cyc = 0;
    exp_t   sb[$];
    int     modelRange[CH];

    int     trigFallCount = 0;
    int     trigRiseCount = 0;
    longint trigFallCyc = 0;
    longint trigRiseCyc = 0;
    int     trigHighCnt = 0;
    int     lastTrigLen = 0;
    int     lastTrigChan = 0;
    logic [CH-1:0] prevTrig = '0;
    int     strobeCount = 0;
    longint strobeCyc = 0;

    ultrasonic_ranger_mc #(
        .CHANNELS       (CH),
        .RANGE_WIDTH    (RW),
        .TRIG_CYCLES    (TRIG),
        .TIMEOUT_CYCLES (TMO),
        .GAP_CYCLES     (GAP)
    ) dut (
        .clk_i            (clk),
        .rst_i            (rst),
        .enable_i         (enable),
        .echo_i           (echo),
        .trigger_o        (trigger),
        .range_o          (rangeBus),
        .result_valid_o   (resultValid),
        .result_chan_o    (resultChan),
        .result_timeout_o (resultTimeout),
        .busy_o           (busy)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input longint observed, input longint expected);
        assertCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", tag, observed, expected, cyc);
        end
    endtask

    // Sampled 1 ns after each rising edge: tracks triggers and scores strobes.
    always @(posedge clk) begin
        logic [CH*RW-1:0] packed_model;
        exp_t e;
        cyc++;
        #1;
        if (trigger != '0) begin
            checkOutput("trig_onehot", $countones(trigger), 1);
            if (prevTrig == '0) begin
                trigRiseCount++;
                trigRiseCyc = cyc;
            end
            trigHighCnt++;
        end else if (prevTrig != '0) begin
            lastTrigLen = trigHighCnt;
            for (int i = 0; i < CH; i++) if (prevTrig[i]) lastTrigChan = i;
            trigHighCnt = 0;
            trigFallCount++;
            trigFallCyc = cyc;
        end
        prevTrig = trigger;

        if (resultValid) begin
            strobeCount++;
            strobeCyc = cyc;
            if (sb.size() == 0) begin
                checkOutput("spurious_strobe", 1, 0);
            end else begin
                e = sb.pop_front();
                modelRange[e.chan] = e.val;
                checkOutput("result_chan", resultChan, e.chan);
                checkOutput("result_timeout", resultTimeout, e.tmo);
                checkOutput("range_slice", rangeBus[e.chan*RW +: RW], e.val);
                if (e.expCyc >= 0) checkOutput("strobe_cycle", cyc, e.expCyc);
                for (int i = 0; i < CH; i++) packed_model[i*RW +: RW] = RW'(modelRange[i]);
                checkOutput("range_all", rangeBus, packed_model);
            end
        end
    end

    task automatic pushExp(input int ch, input int val, input bit tmo, input longint expCyc);
        exp_t e;
        e.chan = ch;
        e.val = val;
        e.tmo = tmo;
        e.expCyc = expCyc;
        sb.push_back(e);
    endtask

    task automatic waitTrigFall(input int expChan);
        int start;
        int n;
        start = trigFallCount;
        n = 0;
        while (trigFallCount == start && n < 400) begin
            @(negedge clk);
            n++;
        end
        checkOutput("trig_wait_done", trigFallCount != start, 1);
        checkOutput("trig_chan", lastTrigChan, expChan);
        checkOutput("trig_len", lastTrigLen, TRIG);
    endtask

    task automatic waitStrobe();
        int start;
        int n;
        start = strobeCount;
        n = 0;
        while (strobeCount == start && n < 400) begin
            @(negedge clk);
            n++;
        end
        checkOutput("strobe_wait_done", strobeCount != start, 1);
    endtask

    task automatic applyStimulus(input int ch, input int delay, input int width);
        repeat (delay) @(negedge clk);
        echo[ch] = 1'b1;
        repeat (width) @(negedge clk);
        echo[ch] = 1'b0;
        pushExp(ch, width, 1'b0, cyc + 3);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int n;
        int rec;
        longint prevStrobe;
        for (int i = 0; i < CH; i++) modelRange[i] = 0;

        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("rst_trigger", trigger, 0);
        checkOutput("rst_range", rangeBus, 0);
        checkOutput("rst_valid", resultValid, 0);
        checkOutput("rst_chan", resultChan, 0);
        checkOutput("rst_timeout", resultTimeout, 0);
        checkOutput("rst_busy", busy, 0);

        enable = 1'b1;
        waitTrigFall(0);
        applyStimulus(0, 4, 37);
        waitStrobe();
        prevStrobe = strobeCyc;

        waitTrigFall(1);
        checkOutput("gap_len", trigRiseCyc - prevStrobe, GAP);
        applyStimulus(1, 4, 20);
        waitStrobe();
        checkOutput("ch0_holds", rangeBus[RW-1:0], 37);

        // Wrap to ch0 with no echo at all.
        waitTrigFall(0);
        pushExp(0, 255, 1'b1, trigFallCyc + TMO);
        waitStrobe();

        // ch1 echo stuck high before it is even triggered.
        echo[1] = 1'b1;
        waitTrigFall(1);
        pushExp(1, 255, 1'b1, trigFallCyc + TMO);
        waitStrobe();
        echo[1] = 1'b0;

        // ch0 echo rises and never falls.
        waitTrigFall(0);
        pushExp(0, 255, 1'b1, trigFallCyc + TMO);
        repeat (3) @(negedge clk);
        echo[0] = 1'b1;
        waitStrobe();
        echo[0] = 1'b0;

        // Reset in the middle of a ch1 measurement.
        waitTrigFall(1);
        repeat (3) @(negedge clk);
        echo[1] = 1'b1;
        repeat (10) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("midrst_trigger", trigger, 0);
        checkOutput("midrst_range", rangeBus, 0);
        checkOutput("midrst_busy", busy, 0);
        checkOutput("midrst_valid", resultValid, 0);
        for (int i = 0; i < CH; i++) modelRange[i] = 0;
        echo[1] = 1'b0;

        // Pointer restarts at ch0; enable drops during MEASURE.
        waitTrigFall(0);
        repeat (4) @(negedge clk);
        echo[0] = 1'b1;
        repeat (5) @(negedge clk);
        enable = 1'b0;
        repeat (10) @(negedge clk);
        echo[0] = 1'b0;
        pushExp(0, 15, 1'b0, cyc + 3);
        waitStrobe();
        n = 0;
        while (busy && n < 50) begin
            @(negedge clk);
            n++;
        end
        checkOutput("busy_fall_after_gap", n, GAP);
        rec = trigRiseCount;
        repeat (30) @(negedge clk);
        checkOutput("no_trig_idle", trigRiseCount - rec, 0);

        enable = 1'b1;
        waitTrigFall(1);
        applyStimulus(1, 4, 9);
        waitStrobe();
        checkOutput("final_range", rangeBus, {8'd9, 8'd15});
        checkOutput("sb_empty", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
